// File: rtl/uart_imem_loader.sv
// uart_imem_loader: assembles ASCII hex from the UART into 32-bit words.
// Define UART_IMEM_LOADER_ECHO_EN to echo every accepted byte before status.
module uart_imem_loader #(
    parameter int unsigned ADDR_W   = 4,
    parameter logic [7:0]  ACK_CHAR = 8'h2E,
    parameter logic [7:0]  ERR_CHAR = 8'h3F,
    parameter logic [7:0]  GO_CHAR  = 8'h21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic [ADDR_W:0]   word_count,
    output logic              load_done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        TX_WAIT,
        TX_HOLD
    } state_t;

    state_t state, state_d;

    logic [7:0]  byte_q;
    logic [31:0] word_q;
    logic [3:0]  nib_cnt;
    logic [31:0] mem [DEPTH];

`ifdef UART_IMEM_LOADER_ECHO_EN
    logic echo_q;
`endif

    logic       is_hex;
    logic       is_sep;
    logic       is_rst;
    logic       is_go;
    logic [3:0] nib;
    logic       full;
    logic       nib_zero;
    logic       last_nib;

    // control strobes produced by the output logic
    logic       accept;
    logic       send;
    logic [7:0] send_byte;
    logic       shift;
    logic       nib_clr;
    logic       wc_clr;
    logic       wc_inc;
    logic       mem_we;
    logic       ld_set;
    logic       ld_clr;
    logic       err_set;
    logic       err_clr;
    logic       tx_pulse;
    logic       echo_set;
    logic       echo_clr;

    assign full     = (word_count == FULL_CNT);
    assign nib_zero = (nib_cnt == 4'd0);
    assign last_nib = (nib_cnt == 4'd7);

    // classify the latched byte
    always_comb begin
        is_hex = 1'b0;
        is_sep = 1'b0;
        is_rst = 1'b0;
        is_go  = 1'b0;
        nib    = 4'd0;
        unique case (1'b1)
            (byte_q >= 8'h30 && byte_q <= 8'h39): begin
                is_hex = 1'b1;
                nib    = byte_q[3:0];
            end
            (byte_q >= 8'h41 && byte_q <= 8'h46),
            (byte_q >= 8'h61 && byte_q <= 8'h66): begin
                is_hex = 1'b1;
                nib    = byte_q[3:0] + 4'd9;
            end
            (byte_q == 8'h20 || byte_q == 8'h0D || byte_q == 8'h0A):
                is_sep = 1'b1;
            (byte_q == 8'h52 || byte_q == 8'h72):
                is_rst = 1'b1;
            (byte_q == 8'h47 || byte_q == 8'h67):
                is_go = 1'b1;
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (rx_rdy) begin
`ifdef UART_IMEM_LOADER_ECHO_EN
                    state_d = TX_WAIT;
`else
                    state_d = DECODE;
`endif
                end
            end
            DECODE: begin
                if (is_hex)
                    state_d = last_nib ? WRITE : IDLE;
                else if (is_sep && nib_zero)
                    state_d = IDLE;
                else
                    state_d = TX_WAIT;
            end
            WRITE:   state_d = TX_WAIT;
            TX_WAIT: if (!tx_busy) state_d = TX_HOLD;
            TX_HOLD: begin
`ifdef UART_IMEM_LOADER_ECHO_EN
                state_d = echo_q ? DECODE : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // per-state control strobes
    always_comb begin
        accept    = 1'b0;
        send      = 1'b0;
        send_byte = 8'h00;
        shift     = 1'b0;
        nib_clr   = 1'b0;
        wc_clr    = 1'b0;
        wc_inc    = 1'b0;
        mem_we    = 1'b0;
        ld_set    = 1'b0;
        ld_clr    = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        tx_pulse  = 1'b0;
        echo_set  = 1'b0;
        echo_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_rdy) begin
                    accept = 1'b1;
`ifdef UART_IMEM_LOADER_ECHO_EN
                    send      = 1'b1;
                    send_byte = rx_data;
                    echo_set  = 1'b1;
`endif
                end
            end
            DECODE: begin
                if (is_hex) begin
                    shift = 1'b1;
                end else if (is_sep) begin
                    if (!nib_zero) begin
                        nib_clr   = 1'b1;
                        err_set   = 1'b1;
                        send      = 1'b1;
                        send_byte = ERR_CHAR;
                    end
                end else if (is_rst) begin
                    wc_clr    = 1'b1;
                    nib_clr   = 1'b1;
                    ld_clr    = 1'b1;
                    err_clr   = 1'b1;
                    send      = 1'b1;
                    send_byte = ACK_CHAR;
                end else if (is_go) begin
                    send = 1'b1;
                    if (nib_zero) begin
                        ld_set    = 1'b1;
                        send_byte = GO_CHAR;
                    end else begin
                        err_set   = 1'b1;
                        send_byte = ERR_CHAR;
                    end
                end else begin
                    err_set   = 1'b1;
                    nib_clr   = 1'b1;
                    send      = 1'b1;
                    send_byte = ERR_CHAR;
                end
            end
            WRITE: begin
                nib_clr = 1'b1;
                send    = 1'b1;
                if (!full) begin
                    mem_we    = 1'b1;
                    wc_inc    = 1'b1;
                    send_byte = ACK_CHAR;
                end else begin
                    err_set   = 1'b1;
                    send_byte = ERR_CHAR;
                end
            end
            TX_WAIT: tx_pulse = !tx_busy;
            TX_HOLD: echo_clr = 1'b1;
            default: ;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q     <= 8'h00;
            word_q     <= 32'h0;
            nib_cnt    <= 4'd0;
            word_count <= '0;
            load_done  <= 1'b0;
            err        <= 1'b0;
            tx_din     <= 8'h00;
            tx_wr_en   <= 1'b0;
            rx_rdy_clr <= 1'b0;
        end else begin
            rx_rdy_clr <= accept;
            tx_wr_en   <= tx_pulse;
            if (accept) byte_q <= rx_data;
            if (send) tx_din <= send_byte;
            if (shift) begin
                word_q  <= {word_q[27:0], nib};
                nib_cnt <= nib_cnt + 4'd1;
            end else if (nib_clr) begin
                word_q  <= 32'h0;
                nib_cnt <= 4'd0;
            end
            if (wc_clr)
                word_count <= '0;
            else if (wc_inc)
                word_count <= word_count + (ADDR_W + 1)'(1);
            if (ld_clr)      load_done <= 1'b0;
            else if (ld_set) load_done <= 1'b1;
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

`ifdef UART_IMEM_LOADER_ECHO_EN
    // remembers that the byte in flight is an echo still awaiting decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           echo_q <= 1'b0;
        else if (echo_set) echo_q <= 1'b1;
        else if (echo_clr) echo_q <= 1'b0;
    end
`endif

    // instruction memory write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_count[ADDR_W-1:0]] <= word_q;
    end

    // registered fetch port; same-cycle write returns old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= 32'h0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed checks of the hex loader.
// Models the UART rx/tx handshakes around the DUT.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_rdy_clr;
    logic        tx_busy;
    logic [7:0]  tx_din;
    logic        tx_wr_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  word_count;
    logic        load_done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int tx_n  = 0;
    logic [7:0] txlog [128];

    uart_imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_busy    (tx_busy),
        .tx_din     (tx_din),
        .tx_wr_en   (tx_wr_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .word_count (word_count),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // log every transmitted byte
    always @(negedge clk) begin
        if (tx_wr_en === 1'b1) begin
            if (tx_n < 128) txlog[tx_n] = tx_din;
            tx_n = tx_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (rx_rdy_clr === 1'b1) got = 1;
        end
        rx_rdy = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rx_handshake byte=%h no rx_rdy_clr, required pulse", b);
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            settle();
        end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] v);
        rd_addr = a;
        @(posedge clk);
        #1;
        v = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        tx_busy = 1'b0;
        rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rd_data, word_count, load_done, err, tx_din, tx_wr_en, rx_rdy_clr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got wc=%0d ld=%b err=%b txd=%h rd=%h, required all 0",
                     word_count, load_done, err, tx_din, rd_data);
        end
        rst = 1'b0;
        settle();
    endtask

    task automatic test_word();
        int base = tx_n;
        logic [31:0] v;
        send_str("DEADBEE");
        total++;
        if (tx_n != base) begin
            bad++;
            $display("FAIL early_tx got %0d bytes, required 0", tx_n - base);
        end
        send_str("F");
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h2E) begin
            bad++;
            $display("FAIL word_ack got n=%0d byte=%h, required n=1 byte=2e", tx_n - base, txlog[base]);
        end
        total++;
        if (word_count !== 5'd1 || err !== 1'b0) begin
            bad++;
            $display("FAIL word_count got wc=%0d err=%b, required wc=1 err=0", word_count, err);
        end
        do_read(4'd0, v);
        total++;
        if (v !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_deadbeef got %h, required deadbeef", v);
        end
    endtask

    task automatic test_sep_err();
        int base = tx_n;
        send_str("1234");
        send_byte(8'h0D);
        settle();
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h3F || err !== 1'b1 || word_count !== 5'd1) begin
            bad++;
            $display("FAIL sep_err got n=%0d byte=%h err=%b wc=%0d, required n=1 3f err=1 wc=1",
                     tx_n - base, txlog[base], err, word_count);
        end
        base = tx_n;
        send_str("r");
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h2E || err !== 1'b0 || word_count !== 5'd0) begin
            bad++;
            $display("FAIL clear_cmd got n=%0d byte=%h err=%b wc=%0d, required n=1 2e err=0 wc=0",
                     tx_n - base, txlog[base], err, word_count);
        end
    endtask

    task automatic test_full();
        int base = tx_n;
        logic [31:0] v;
        for (int i = 0; i < 16; i++)
            send_str($sformatf("%08x", 32'h1000_0000 + i));
        total++;
        if (tx_n - base != 16 || txlog[base + 15] !== 8'h2E || word_count !== 5'd16 || err !== 1'b0) begin
            bad++;
            $display("FAIL fill got n=%0d wc=%0d err=%b, required n=16 wc=16 err=0",
                     tx_n - base, word_count, err);
        end
        base = tx_n;
        send_str("00000001");
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h3F || word_count !== 5'd16 || err !== 1'b1) begin
            bad++;
            $display("FAIL overflow got n=%0d byte=%h wc=%0d err=%b, required n=1 3f wc=16 err=1",
                     tx_n - base, txlog[base], word_count, err);
        end
        do_read(4'd0, v);
        total++;
        if (v !== 32'h1000_0000) begin
            bad++;
            $display("FAIL mem0_kept got %h, required 10000000", v);
        end
        do_read(4'd15, v);
        total++;
        if (v !== 32'h1000_000F) begin
            bad++;
            $display("FAIL mem15 got %h, required 1000000f", v);
        end
    endtask

    task automatic test_go();
        int base;
        logic [31:0] v;
        send_str("r");
        base = tx_n;
        send_str("cafef00d");
        send_byte(8'h20);
        settle();
        send_byte(8'h0A);
        settle();
        send_str("G");
        total++;
        if (tx_n - base != 2 || txlog[base] !== 8'h2E || txlog[base + 1] !== 8'h21) begin
            bad++;
            $display("FAIL go_seq got n=%0d %h %h, required n=2 2e 21",
                     tx_n - base, txlog[base], txlog[base + 1]);
        end
        total++;
        if (load_done !== 1'b1 || err !== 1'b0 || word_count !== 5'd1) begin
            bad++;
            $display("FAIL go_flags got ld=%b err=%b wc=%0d, required ld=1 err=0 wc=1",
                     load_done, err, word_count);
        end
        do_read(4'd0, v);
        total++;
        if (v !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL read_cafef00d got %h, required cafef00d", v);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int clr_seen = 0;
        bit got = 0;
        logic [31:0] v;
        tx_busy = 1'b1;
        base = tx_n;
        send_str("11223344");
        rx_data = 8'h20;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rx_rdy_clr === 1'b1) clr_seen++;
        end
        total++;
        if (tx_n != base || clr_seen != 0) begin
            bad++;
            $display("FAIL busy_hold got tx=%0d clr=%0d, required 0 and 0", tx_n - base, clr_seen);
        end
        tx_busy = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (rx_rdy_clr === 1'b1) got = 1;
        end
        rx_rdy = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL pending_accept got no clr, required pulse");
        end
        settle();
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h2E || word_count !== 5'd2) begin
            bad++;
            $display("FAIL busy_release got n=%0d byte=%h wc=%0d, required n=1 2e wc=2",
                     tx_n - base, txlog[base], word_count);
        end
        do_read(4'd1, v);
        total++;
        if (v !== 32'h11223344) begin
            bad++;
            $display("FAIL read_11223344 got %h, required 11223344", v);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        logic [31:0] v;
        send_str("ABC");
        #2;
        rst = 1'b1;
        #2;
        total++;
        if ({rd_data, word_count, load_done, err, tx_din, tx_wr_en, rx_rdy_clr} !== '0) begin
            bad++;
            $display("FAIL mid_reset got wc=%0d ld=%b err=%b txd=%h rd=%h, required all 0",
                     word_count, load_done, err, tx_din, rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        base = tx_n;
        send_str("12345678");
        total++;
        if (tx_n - base != 1 || txlog[base] !== 8'h2E || word_count !== 5'd1) begin
            bad++;
            $display("FAIL post_reset_word got n=%0d byte=%h wc=%0d, required n=1 2e wc=1",
                     tx_n - base, txlog[base], word_count);
        end
        do_read(4'd0, v);
        total++;
        if (v !== 32'h12345678) begin
            bad++;
            $display("FAIL read_12345678 got %h, required 12345678", v);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sep_err();
        test_full();
        test_go();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
